// File: rtl/clk_en_rst_seq_if.sv
// Control/status bundle between a host and the clock-enable / reset sequencer.
// The host drives the requests and configuration. The sequencer drives reset, status and ticks.
interface clk_en_rst_seq_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 16,
  parameter int RST_CNT_W = 20
);
  logic                      sw_rst_req_i;
  logic [RST_CNT_W-1:0]      rst_hold_i;
  logic [NUM_CH-1:0]         ch_en_i;
  logic [NUM_CH*DIV_W-1:0]   div_val_i;
  logic                      rst_out_n;
  logic                      busy_o;
  logic                      rst_done_o;
  logic [NUM_CH-1:0]         ce_o;
  logic [NUM_CH-1:0]         tog_o;

  modport master (
    output sw_rst_req_i, rst_hold_i, ch_en_i, div_val_i,
    input  rst_out_n, busy_o, rst_done_o, ce_o, tog_o
  );

  modport slave (
    input  sw_rst_req_i, rst_hold_i, ch_en_i, div_val_i,
    output rst_out_n, busy_o, rst_done_o, ce_o, tog_o
  );
endinterface

// File: rtl/clk_en_rst_seq.sv
// Reset sequencer (pre-delay / hold / post-delay) plus NUM_CH divide-by-N tick channels.
// Every output is registered. The channels stay cleared while the sequenced reset is low.
module clk_en_rst_seq #(
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 16,
  parameter int RST_CNT_W      = 20,
  parameter int DEF_RST_CYCLES = 5000,
  parameter int PRE_CYCLES     = 2,
  parameter int POST_CYCLES    = 8
) (
  input  logic               bus_clk,
  input  logic               rst_sys,
  clk_en_rst_seq_if.slave    io
);

  // IDLE wait req | PRE pre-delay | HOLD rst_out_n low | POST post-delay | DONE done pulse
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HOLD, S_POST, S_DONE} state_e;

  localparam logic [RST_CNT_W-1:0] CNT_ONE = RST_CNT_W'(1);
  localparam logic [RST_CNT_W-1:0] PRE_LD  = RST_CNT_W'(PRE_CYCLES);
  localparam logic [RST_CNT_W-1:0] POST_LD = RST_CNT_W'(POST_CYCLES);
  localparam logic [RST_CNT_W-1:0] DEF_LD  = RST_CNT_W'(DEF_RST_CYCLES);

  state_e               state_q, state_d;
  logic [RST_CNT_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [RST_CNT_W-1:0] hold_q, hold_d;
  logic                 rst_n_q, busy_q, done_q;
  logic                 rst_n_d;

  always_comb begin
    state_d   = state_q;
    seq_cnt_d = seq_cnt_q;
    hold_d    = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (io.sw_rst_req_i) begin
          state_d   = S_PRE;
          seq_cnt_d = PRE_LD;
          hold_d    = (io.rst_hold_i == '0) ? CNT_ONE : io.rst_hold_i;
        end
      end
      S_PRE: begin
        if (seq_cnt_q <= CNT_ONE) begin
          state_d   = S_HOLD;
          seq_cnt_d = hold_q;
        end else begin
          seq_cnt_d = seq_cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (seq_cnt_q <= CNT_ONE) begin
          state_d   = S_POST;
          seq_cnt_d = POST_LD;
        end else begin
          seq_cnt_d = seq_cnt_q - CNT_ONE;
        end
      end
      S_POST: begin
        if (seq_cnt_q <= CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          seq_cnt_d = seq_cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rst_n_d = (state_d != S_HOLD);
  end

  // The cycle that is live as rst_sys falls is the first of the DEF_RST_CYCLES hold cycles.
  always_ff @(posedge bus_clk) begin
    if (rst_sys) begin
      state_q   <= S_HOLD;
      seq_cnt_q <= DEF_LD;
      hold_q    <= CNT_ONE;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_cnt_q <= seq_cnt_d;
      hold_q    <= hold_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= (state_d == S_PRE) || (state_d == S_HOLD) || (state_d == S_POST);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign io.rst_out_n  = rst_n_q;
  assign io.busy_o     = busy_q;
  assign io.rst_done_o = done_q;

  logic [NUM_CH-1:0] ce_vec, tog_vec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, div_q;
    logic             ce_q, tog_q, en_q;
    logic [DIV_W-1:0] div_in;
    logic             run, wrap;

    assign div_in = io.div_val_i[k*DIV_W +: DIV_W];
    // Clearing on both the current and the previous enable/reset level puts the first tick D edges after start.
    assign run    = rst_n_d & rst_n_q & io.ch_en_i[k] & en_q;
    assign wrap   = (div_q <= DIV_W'(1)) || (cnt_q == div_q - DIV_W'(1));

    always_ff @(posedge bus_clk) begin
      if (rst_sys) begin
        en_q  <= 1'b0;
        cnt_q <= '0;
        div_q <= div_in;
        ce_q  <= 1'b0;
        tog_q <= 1'b0;
      end else begin
        en_q <= io.ch_en_i[k];
        if (!run) begin
          cnt_q <= '0;
          div_q <= div_in;
          ce_q  <= 1'b0;
          tog_q <= 1'b0;
        end else if (wrap) begin
          cnt_q <= '0;
          div_q <= div_in;
          ce_q  <= 1'b1;
          tog_q <= ~tog_q;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
          ce_q  <= 1'b0;
        end
      end
    end

    assign ce_vec[k]  = ce_q;
    assign tog_vec[k] = tog_q;
  end

  assign io.ce_o  = ce_vec;
  assign io.tog_o = tog_vec;

endmodule

// File: tb/tb_clk_en_rst_seq.sv
// Scoreboard bench for clk_en_rst_seq: each stimulus pushes per-cycle expectations,
// and a negedge monitor pops one entry per cycle and compares it with the outputs.
module tb_clk_en_rst_seq;
  localparam int NCH     = 4;
  localparam int DW      = 16;
  localparam int RW      = 20;
  localparam int TB_DEF  = 16;
  localparam int TB_PRE  = 2;
  localparam int TB_POST = 8;

  logic clk = 1'b0;
  logic rst_sys;
  int   cyc = 0;

  clk_en_rst_seq_if #(.NUM_CH(NCH), .DIV_W(DW), .RST_CNT_W(RW)) bus ();

  clk_en_rst_seq #(
    .NUM_CH(NCH), .DIV_W(DW), .RST_CNT_W(RW),
    .DEF_RST_CYCLES(TB_DEF), .PRE_CYCLES(TB_PRE), .POST_CYCLES(TB_POST)
  ) dut (
    .bus_clk(clk),
    .rst_sys(rst_sys),
    .io     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         chk_seq;
    logic       rst_n;
    logic       busy;
    logic       done;
    bit         chk_ch;
    logic [3:0] ce;
    logic [3:0] tog;
  } exp_t;

  exp_t exp_q[$];
  exp_t plan[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk_seq) begin
        check_eq("rst_out_n",  32'(bus.rst_out_n),  32'(e.rst_n));
        check_eq("busy_o",     32'(bus.busy_o),     32'(e.busy));
        check_eq("rst_done_o", 32'(bus.rst_done_o), 32'(e.done));
      end
      if (e.chk_ch) begin
        check_eq("ce_o",  32'(bus.ce_o),  32'(e.ce));
        check_eq("tog_o", 32'(bus.tog_o), 32'(e.tog));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grow(input int n);
    exp_t e;
    e.chk_seq = 1'b0; e.rst_n = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    e.chk_ch  = 1'b0; e.ce = '0; e.tog = '0;
    while (plan.size() < n) plan.push_back(e);
  endtask

  task automatic plan_add(input int n, input logic rn, input logic b, input logic d, input bit ch_off);
    exp_t e;
    e.chk_seq = 1'b1; e.rst_n = rn; e.busy = b; e.done = d;
    e.chk_ch  = ch_off; e.ce = '0; e.tog = '0;
    for (int i = 0; i < n; i++) plan.push_back(e);
  endtask

  // Software sequence as seen from the cycle in which the request is driven.
  task automatic plan_sw(input int h, input bit ch_off);
    plan_add(1, 1'b1, 1'b0, 1'b0, ch_off);
    plan_add(TB_PRE, 1'b1, 1'b1, 1'b0, ch_off);
    plan_add((h == 0) ? 1 : h, 1'b0, 1'b1, 1'b0, ch_off);
    plan_add(TB_POST, 1'b1, 1'b1, 1'b0, ch_off);
    plan_add(1, 1'b1, 1'b0, 1'b1, ch_off);
    plan_add(1, 1'b1, 1'b0, 1'b0, ch_off);
  endtask

  task automatic plan_zero(input int origin, input int n);
    exp_t e;
    grow(origin + n);
    for (int j = 0; j < n; j++) begin
      e = plan[origin + j];
      e.chk_ch = 1'b1; e.ce = '0; e.tog = '0;
      plan[origin + j] = e;
    end
  endtask

  // Entry 'origin' is the last cleared cycle; a channel ticks D entries later, then every period.
  task automatic plan_ch(input int origin, input int n, input logic [3:0] mask,
                         input int d0, input int d1, input int d2, input int d3, input int d0_next);
    int   df[4];
    int   nxt;
    logic t;
    exp_t e;
    df[0] = d0; df[1] = d1; df[2] = d2; df[3] = d3;
    grow(origin + n);
    for (int k = 0; k < 4; k++) begin
      nxt = (df[k] < 1) ? 1 : df[k];
      t   = 1'b0;
      for (int j = 0; j < n; j++) begin
        e = plan[origin + j];
        e.chk_ch = 1'b1;
        if (mask[k] && j == nxt) begin
          e.ce[k] = 1'b1;
          t = ~t;
          if (k == 0) nxt += (d0_next < 1) ? 1 : d0_next;
          else        nxt += (df[k] < 1) ? 1 : df[k];
        end else begin
          e.ce[k] = 1'b0;
        end
        e.tog[k] = t;
        plan[origin + j] = e;
      end
    end
  endtask

  task automatic commit();
    foreach (plan[i]) exp_q.push_back(plan[i]);
    plan.delete();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_sys          = 1'b1;
    bus.sw_rst_req_i = 1'b0;
    bus.rst_hold_i   = '0;
    bus.ch_en_i      = '0;
    bus.div_val_i    = '0;

    // Power-on: three reset edges, then the full default hold, post-delay and done pulse.
    step();
    plan_add(1, 1'b0, 1'b1, 1'b0, 1'b1);
    commit();
    step();
    step();
    rst_sys = 1'b0;
    plan_add(TB_DEF, 1'b0, 1'b1, 1'b0, 1'b1);
    plan_add(TB_POST, 1'b1, 1'b1, 1'b0, 1'b1);
    plan_add(1, 1'b1, 1'b0, 1'b1, 1'b1);
    plan_add(1, 1'b1, 1'b0, 1'b0, 1'b1);
    commit();
    wait_drain(100);

    // Software request with hold 5; a second request lands mid-HOLD and must be ignored.
    step();
    bus.sw_rst_req_i = 1'b1;
    bus.rst_hold_i   = RW'(5);
    plan_sw(5, 1'b1);
    commit();
    step();
    bus.sw_rst_req_i = 1'b0;
    step(); step(); step(); step();
    bus.sw_rst_req_i = 1'b1;
    bus.rst_hold_i   = RW'(20);
    step();
    bus.sw_rst_req_i = 1'b0;
    wait_drain(100);

    // Zero hold behaves as a single low cycle.
    step();
    bus.sw_rst_req_i = 1'b1;
    bus.rst_hold_i   = '0;
    plan_sw(0, 1'b1);
    commit();
    step();
    bus.sw_rst_req_i = 1'b0;
    wait_drain(100);

    // Dividers 4, 1, 0, 10 on all channels.
    step();
    bus.div_val_i = {16'd10, 16'd0, 16'd1, 16'd4};
    bus.ch_en_i   = 4'hF;
    plan_zero(0, 1);
    plan_ch(1, 41, 4'hF, 4, 1, 0, 10, 4);
    commit();
    wait_drain(100);

    // Divisor change from 4 to 6 while channel 0 holds cnt=1.
    step();
    bus.ch_en_i = 4'h0;
    step();
    bus.ch_en_i   = 4'h1;
    bus.div_val_i = {16'd10, 16'd0, 16'd1, 16'd4};
    plan_zero(0, 1);
    plan_ch(1, 24, 4'h1, 4, 4, 4, 4, 6);
    commit();
    step();
    step();
    bus.div_val_i = {16'd10, 16'd0, 16'd1, 16'd6};
    wait_drain(100);

    // Drop channel 0 enable mid-count, then re-enable with D=4.
    step();
    bus.ch_en_i   = 4'h0;
    bus.div_val_i = {16'd10, 16'd0, 16'd1, 16'd4};
    step();
    plan_zero(0, 2);
    commit();
    step();
    step();
    bus.ch_en_i = 4'h1;
    plan_zero(0, 1);
    plan_ch(1, 20, 4'h1, 4, 4, 4, 4, 4);
    commit();
    wait_drain(100);

    // Software reset while all channels start: ticks during PRE, silence in HOLD, restart after release.
    step();
    bus.ch_en_i = 4'h0;
    step();
    bus.ch_en_i      = 4'hF;
    bus.div_val_i    = {16'd3, 16'd0, 16'd1, 16'd4};
    bus.sw_rst_req_i = 1'b1;
    bus.rst_hold_i   = RW'(5);
    plan_sw(5, 1'b0);
    plan_zero(0, 1);
    plan_ch(1, 2, 4'hF, 4, 1, 0, 3, 4);
    plan_zero(3, 5);
    plan_ch(8, 20, 4'hF, 4, 1, 0, 3, 4);
    commit();
    step();
    bus.sw_rst_req_i = 1'b0;
    wait_drain(100);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_en_rst_seq.md
Name: clk_en_rst_seq

Overview:
- Synthesizable clock-enable generator and reset sequencer running on the single bus clock.
- Replaces fixed free-running per-rate clocks with NUM_CH programmable divide-by-N tick channels.
- Adds a deterministic pre-delay / hold / post-delay reset sequence, started at power-on or on software request.
- Feeds the RTC, MAC TX and bus logic with enables and a sequenced active-low reset.

Parameters:
NUM_CH, 4, number of independent tick channels
DIV_W, 16, width of each channel divisor
RST_CNT_W, 20, width of reset hold counter
DEF_RST_CYCLES, 5000, hold length used after rst_sys release
PRE_CYCLES, 2, cycles between request and reset assertion (>=1)
POST_CYCLES, 8, cycles between reset release and done pulse (>=1)

Ports:
bus_clk  input  1  single clock
rst_sys  input  1  synchronous, active-high reset
sw_rst_req_i  input  1  start reset sequence; level sampled each cycle
rst_hold_i  input  RST_CNT_W  hold length for software sequence
ch_en_i  input  NUM_CH  per-channel enable
div_val_i  input  NUM_CH*DIV_W  channel k divisor in bits [k*DIV_W +: DIV_W]
rst_out_n  output  1  sequenced active-low reset for downstream logic
busy_o  output  1  sequencer not idle
rst_done_o  output  1  one-cycle pulse at sequence end
ce_o  output  NUM_CH  one-cycle tick per channel
tog_o  output  NUM_CH  toggles on every tick (50% square at 2N)

Behaviour:
- Clock and reset: one clock, bus_clk. Reset rst_sys is synchronous and active-high.
- Values while rst_sys is high:
  - rst_out_n=0, busy_o=1, rst_done_o=0, ce_o=0, tog_o=0.
  - FSM=HOLD, hold counter loaded with DEF_RST_CYCLES.
- FSM states: IDLE, PRE, HOLD, POST, DONE. All outputs are registered.
- IDLE:
  - If sw_rst_req_i is high at edge k: enter PRE and latch rst_hold_i as H.
  - H=0 is treated as 1.
- PRE:
  - Lasts PRE_CYCLES cycles; rst_out_n stays 1.
  - Then enters HOLD.
- HOLD:
  - rst_out_n=0 for exactly H cycles, covering edges k+PRE_CYCLES .. k+PRE_CYCLES+H-1.
  - Then enters POST.
- POST:
  - rst_out_n=1 for POST_CYCLES cycles.
  - Then enters DONE.
- DONE:
  - Lasts one cycle with rst_done_o=1 and busy_o=0.
  - Then returns to IDLE.
- Power-on path: after rst_sys falls, HOLD runs the remaining DEF_RST_CYCLES cycles (counted from the first cycle with rst_sys low), then POST, then DONE.
- busy_o=1 in PRE, HOLD and POST; busy_o=0 in IDLE and DONE.
- Requests during PRE, HOLD, POST or DONE are ignored; there is no queuing.
- rst_sys high mid-sequence restarts at HOLD with DEF_RST_CYCLES.
- Channel k logic:
  - Has its own DIV_W counter cnt and active divisor D.
  - The channel is cleared (cnt=0, ce=0, tog=0, D reloaded from div_val_i) when rst_out_n=0 or ch_en_i[k]=0.
- Channel k enabled:
  - cnt increments each cycle.
  - When cnt==D-1: ce_o[k]=1 for one cycle, tog_o[k] inverts, cnt wraps to 0, and D reloads from div_val_i.
- Divisor change rules:
  - div_val_i changes take effect only at a wrap, so there are no short or long glitch periods mid-period.
  - D=0 or D=1 gives ce_o[k]=1 every cycle, with tog_o toggling each cycle.
- Timing after enable:
  - Enable sampled at edge e (or reset released at edge e) gives the first ce at edge e+D, then every D cycles.
- Channels are fully independent; simultaneous ticks are allowed.

Test Plan:
- Power-on, bench DEF_RST_CYCLES=16, POST_CYCLES=8, PRE_CYCLES=2:
  - Stimulus: rst_sys high 3 cycles, then low.
  - Required: rst_out_n low 16 cycles after release, high 8 cycles before rst_done_o pulses once; busy_o falls with the pulse.
- Software reset:
  - Stimulus: in IDLE, pulse sw_rst_req_i one cycle with rst_hold_i=5.
  - Required: rst_out_n rises... specifically stays 1 for 2 cycles, is low exactly 5 cycles, then rst_done_o pulses 8 cycles after release. A second request mid-HOLD has no effect.
- Zero hold:
  - Stimulus: rst_hold_i=0.
  - Required: rst_out_n low exactly 1 cycle.
- Divider:
  - Stimulus: ch0 D=4, ch1 D=1, ch2 D=0, ch3 D=10, all enabled.
  - Required: ce_o[0] every 4 cycles; ce_o[1] and ce_o[2] continuous; ce_o[3] every 10 cycles; tog_o[0] period 8.
- Divisor change:
  - Stimulus: ch0 running D=4; change div_val to 6 at cnt=1.
  - Required: current period still 4, next period 6.
- Enable/reset interaction:
  - Stimulus: deassert ch_en_i[0] mid-count, reassert at edge e; separately trigger a software reset.
  - Required: first tick at e+D. During rst_out_n=0, all ce_o=0 and tog_o=0; after release, ticks restart at D cycles.
